// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for the 16-bit RISC datapath.
// Sequences IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT and decodes datapath strobes from state and opcode.
module mc_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst_link,
    output logic       wb_s2,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_ANDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_CALL = 4'd10;
    localparam logic [3:0] OP_RET  = 4'd11;
    localparam logic [3:0] OP_LUI  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t     state, next;
    logic [2:0] wb;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next         = state;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        reg_dst_link = 1'b0;
        wb           = 3'b000;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    next     = DECODE;
                end
            end
            DECODE: case (opcode)
                OP_JMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    next     = FETCH;
                end
                OP_RET: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b11;
                    next     = FETCH;
                end
                OP_CALL, OP_LUI: next = WB;
                OP_HALT:         next = HALT;
                4'd13, 4'd14:    next = FETCH;
                default:         next = EXEC;
            endcase
            EXEC: case (opcode)
                OP_AND:  begin alu_op = 2'b10; next = WB; end
                OP_ADD:  next = WB;
                OP_SUB:  begin alu_op = 2'b01; next = WB; end
                OP_ADDI: begin alu_src_b = 1'b1; next = WB; end
                OP_ANDI: begin alu_src_b = 1'b1; alu_op = 2'b10; next = WB; end
                OP_LW, OP_SW: begin alu_src_b = 1'b1; next = MEM; end
                OP_BEQ, OP_BNE: begin
                    alu_op   = 2'b01;
                    pc_src   = 2'b01;
                    pc_write = (opcode == OP_BEQ) ? zero : !zero;
                    next     = FETCH;
                end
                default: next = FETCH;
            endcase
            MEM: begin
                i_or_d    = 1'b1;
                mem_write = (opcode == OP_SW);
                mem_read  = (opcode != OP_SW);
                if (mem_ready) next = (opcode == OP_SW) ? FETCH : WB;
            end
            WB: begin
                reg_write = 1'b1;
                next      = FETCH;
                case (opcode)
                    OP_LW:  wb = 3'b001;
                    OP_LUI: wb = 3'b100;
                    OP_CALL: begin
                        wb           = 3'b011;
                        reg_dst_link = 1'b1;
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                    end
                    default: wb = 3'b000;
                endcase
            end
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end

    assign {wb_s2, wb_s1, wb_s0} = wb;
    assign state_o = state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench; each scenario queues per-cycle expected state and strobes,
// then drives the matching inputs and compares as entries are popped.
module tb_mc_control_unit;
    logic       clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_b;
    logic       reg_write, reg_dst_link, wb_s2, wb_s1, wb_s0;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state_o;
    logic [14:0] outs;
    int n_checks = 0, n_fail = 0;

    // Packed strobe vector: [14] pc_write [13:12] pc_src [11] ir_write [10] mem_read [9] mem_write
    // [8] i_or_d [7] alu_src_b [6:5] alu_op [4] reg_write [3] reg_dst_link [2:0] wb select
    localparam logic [14:0] PW = 15'h4000, PS_BR = 15'h1000, PS_J = 15'h2000, PS_R = 15'h3000;
    localparam logic [14:0] IRW = 15'h0800, MR = 15'h0400, MW = 15'h0200, IOD = 15'h0100;
    localparam logic [14:0] ASB = 15'h0080, A_SUB = 15'h0020, A_AND = 15'h0040;
    localparam logic [14:0] RW = 15'h0010, LNK = 15'h0008, W_MEM = 15'h0001, W_PC1 = 15'h0003, W_SH = 15'h0004;
    localparam logic [14:0] F_GO = MR | IRW | PW;

    typedef struct {
        logic r, mr, z;
        logic [3:0] op;
        logic [2:0] st;
        logic [14:0] o;
    } step_t;
    step_t sb[$];

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst_link(reg_dst_link),
        .wb_s2(wb_s2), .wb_s1(wb_s1), .wb_s0(wb_s0), .state_o(state_o)
    );

    assign outs = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, alu_src_b,
                   alu_op, reg_write, reg_dst_link, wb_s2, wb_s1, wb_s0};

    task automatic push(input logic r, input logic mr, input logic z, input logic [3:0] op,
                        input logic [2:0] st, input logic [14:0] o);
        step_t s;
        s.r = r; s.mr = mr; s.z = z; s.op = op; s.st = st; s.o = o;
        sb.push_back(s);
    endtask

    task automatic test_reset();
        step_t s;
        int k = 0;
        repeat (3) push(1, 1, 0, 4'd1, 3'd0, 15'h0);
        push(0, 1, 0, 4'd1, 3'd0, 15'h0);
        push(0, 0, 0, 4'd1, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL reset step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL reset step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    task automatic test_add();
        step_t s;
        int k = 0;
        push(0, 1, 0, 4'd1, 3'd1, F_GO);
        push(0, 1, 0, 4'd1, 3'd2, 15'h0);
        push(0, 1, 0, 4'd1, 3'd3, 15'h0);
        push(0, 1, 0, 4'd1, 3'd5, RW);
        push(0, 0, 0, 4'd1, 3'd1, MR);
        push(0, 1, 0, 4'd0, 3'd1, F_GO);
        push(0, 1, 0, 4'd0, 3'd2, 15'h0);
        push(0, 1, 0, 4'd0, 3'd3, A_AND);
        push(0, 1, 0, 4'd0, 3'd5, RW);
        push(0, 1, 0, 4'd4, 3'd1, F_GO);
        push(0, 1, 0, 4'd4, 3'd2, 15'h0);
        push(0, 1, 0, 4'd4, 3'd3, ASB | A_AND);
        push(0, 1, 0, 4'd4, 3'd5, RW);
        push(0, 0, 0, 4'd4, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL alu step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL alu step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    task automatic test_lw_stall();
        step_t s;
        int k = 0;
        push(0, 1, 0, 4'd5, 3'd1, F_GO);
        push(0, 1, 0, 4'd5, 3'd2, 15'h0);
        push(0, 1, 0, 4'd5, 3'd3, ASB);
        push(0, 0, 0, 4'd5, 3'd4, MR | IOD);
        push(0, 0, 0, 4'd5, 3'd4, MR | IOD);
        push(0, 1, 0, 4'd5, 3'd4, MR | IOD);
        push(0, 1, 0, 4'd5, 3'd5, RW | W_MEM);
        push(0, 0, 0, 4'd5, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL lw step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL lw step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    task automatic test_branch();
        step_t s;
        int k = 0;
        push(0, 1, 1, 4'd7, 3'd1, F_GO);
        push(0, 1, 1, 4'd7, 3'd2, 15'h0);
        push(0, 1, 1, 4'd7, 3'd3, A_SUB | PS_BR | PW);
        push(0, 1, 1, 4'd7, 3'd1, F_GO);
        push(0, 1, 1, 4'd7, 3'd2, 15'h0);
        push(0, 1, 0, 4'd7, 3'd3, A_SUB | PS_BR);
        push(0, 1, 0, 4'd8, 3'd1, F_GO);
        push(0, 1, 0, 4'd8, 3'd2, 15'h0);
        push(0, 1, 0, 4'd8, 3'd3, A_SUB | PS_BR | PW);
        push(0, 1, 0, 4'd8, 3'd1, F_GO);
        push(0, 1, 0, 4'd8, 3'd2, 15'h0);
        push(0, 1, 1, 4'd8, 3'd3, A_SUB | PS_BR);
        push(0, 0, 1, 4'd8, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL branch step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL branch step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    task automatic test_call_jumps();
        step_t s;
        int k = 0;
        push(0, 1, 0, 4'd10, 3'd1, F_GO);
        push(0, 1, 0, 4'd10, 3'd2, 15'h0);
        push(0, 1, 0, 4'd10, 3'd5, RW | LNK | W_PC1 | PW | PS_J);
        push(0, 1, 0, 4'd12, 3'd1, F_GO);
        push(0, 1, 0, 4'd12, 3'd2, 15'h0);
        push(0, 1, 0, 4'd12, 3'd5, RW | W_SH);
        push(0, 1, 0, 4'd9, 3'd1, F_GO);
        push(0, 1, 0, 4'd9, 3'd2, PW | PS_J);
        push(0, 1, 0, 4'd11, 3'd1, F_GO);
        push(0, 1, 0, 4'd11, 3'd2, PW | PS_R);
        push(0, 1, 0, 4'd13, 3'd1, F_GO);
        push(0, 1, 0, 4'd13, 3'd2, 15'h0);
        push(0, 0, 0, 4'd13, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL call/jump step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL call/jump step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    task automatic test_sw_reset();
        step_t s;
        int k = 0;
        push(0, 1, 0, 4'd6, 3'd1, F_GO);
        push(0, 1, 0, 4'd6, 3'd2, 15'h0);
        push(0, 1, 0, 4'd6, 3'd3, ASB);
        push(0, 1, 0, 4'd6, 3'd4, MW | IOD);
        push(0, 1, 0, 4'd6, 3'd1, F_GO);
        push(0, 1, 0, 4'd6, 3'd2, 15'h0);
        push(0, 1, 0, 4'd6, 3'd3, ASB);
        push(0, 0, 0, 4'd6, 3'd4, MW | IOD);
        push(1, 1, 0, 4'd6, 3'd4, MW | IOD);
        push(0, 0, 0, 4'd6, 3'd0, 15'h0);
        push(0, 0, 0, 4'd6, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL sw/reset step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL sw/reset step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    task automatic test_halt();
        step_t s;
        int k = 0;
        push(0, 1, 0, 4'd15, 3'd1, F_GO);
        push(0, 1, 0, 4'd15, 3'd2, 15'h0);
        for (int i = 0; i < 10; i++) push(0, 1, logic'(i[0]), 4'(i), 3'd6, 15'h0);
        push(1, 1, 0, 4'd1, 3'd6, 15'h0);
        push(0, 1, 0, 4'd1, 3'd0, 15'h0);
        push(0, 0, 0, 4'd1, 3'd1, MR);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.r; mem_ready = s.mr; zero = s.z; opcode = s.op; #1;
            n_checks++;
            if (state_o !== s.st) begin n_fail++; $display("FAIL halt step %0d state: got %b want %b", k, state_o, s.st); end
            n_checks++;
            if (outs !== s.o) begin n_fail++; $display("FAIL halt step %0d outs: got %h want %h", k, outs, s.o); end
            k++;
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_call_jumps();
        test_sw_reset();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
